led_column_scanner: RTL and testbench

LED_COLUMN_SCANNER -- requirements
Module: led_column_scanner

---
 rtl/led_column_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_led_column_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_column_scanner.sv
// Column scanner for a rotating HUB75-style LED panel.
// Per scan address: fetch a column pair, then for each bit-plane (MSB first)
// shift NUM_ROWS pixels, latch, and display for BCM_BASE<<plane cycles.
// Optional macro FRAME_SYNC_EN: a theta strobe outside IDLE restarts the
// scan at address 0 with the new theta instead of waiting for the wrap.
module led_column_scanner #(
    parameter int unsigned SCAN_RATE      = 32,
    parameter int unsigned NUM_ROWS       = 64,
    parameter int unsigned RGB_RES        = 9,
    parameter int unsigned ROTATIONAL_RES = 256,
    parameter int unsigned BCM_BASE       = 4
) (
    input  logic                                       clk_in,
    input  logic                                       rst_n_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0]          theta_in,
    input  logic                                       theta_valid_in,
    output logic [$clog2(ROTATIONAL_RES)-1:0]          dtheta_out,
    output logic [$clog2(SCAN_RATE)-1:0]               column_index1_out,
    output logic [$clog2(SCAN_RATE)-1:0]               column_index2_out,
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]      columns_in,
    output logic [2:0]                                 rgb1_out,
    output logic [2:0]                                 rgb2_out,
    output logic                                       sclk_out,
    output logic                                       latch_out,
    output logic                                       oe_n_out,
    output logic [$clog2(SCAN_RATE)-1:0]               addr_out
);

    localparam int unsigned ThW      = $clog2(ROTATIONAL_RES);
    localparam int unsigned AW       = $clog2(SCAN_RATE);
    localparam int unsigned P        = RGB_RES / 3;
    localparam int unsigned PW       = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned KW       = $clog2(NUM_ROWS);
    localparam int unsigned ShiftLen = 2 * NUM_ROWS;
    localparam int unsigned DispMax  = BCM_BASE << (P - 1);
    localparam int unsigned CntMax   = (ShiftLen > DispMax) ? ShiftLen : DispMax;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StLatch,
        StDisplay
    } state_e;

    state_e                               state_q, state_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [PW-1:0]                        plane_q, plane_d;
    logic [AW-1:0]                        a_q, a_d;
    logic [ThW-1:0]                       theta_q, theta_d;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] buf_q, buf_d;
    logic [ThW-1:0]                       dtheta_q, dtheta_d;
    logic [AW-1:0]                        col_q, col_d;
    logic [AW-1:0]                        addr_q, addr_d;
`ifndef FRAME_SYNC_EN
    logic [ThW-1:0]                       pend_theta_q, pend_theta_d;
    logic                                 pend_vld_q, pend_vld_d;
`endif

    logic [CntW-1:0]    disp_last;
    logic [KW-1:0]      pix_k;
    logic [RGB_RES-1:0] pix1, pix2;
    logic [P-1:0]       plane_oh;

    assign disp_last = CntW'(BCM_BASE << plane_q) - CntW'(1);
    // Two cycles per pixel: bit 0 of the counter is the sclk phase.
    assign pix_k     = cnt_q[KW:1];
    assign pix1      = buf_q[0][pix_k];
    assign pix2      = buf_q[1][pix_k];
    assign plane_oh  = {{(P - 1){1'b0}}, 1'b1} << plane_q;

    // Next-state logic for the scan sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        plane_d  = plane_q;
        a_d      = a_q;
        theta_d  = theta_q;
        buf_d    = buf_q;
        dtheta_d = dtheta_q;
        col_d    = col_q;
        addr_d   = addr_q;
`ifndef FRAME_SYNC_EN
        pend_theta_d = pend_theta_q;
        pend_vld_d   = pend_vld_q;
        if (state_q != StIdle && theta_valid_in) begin
            pend_theta_d = theta_in;
            pend_vld_d   = 1'b1;
        end
`endif

        unique case (state_q)
            StIdle: begin
                if (theta_valid_in) begin
                    theta_d = theta_in;
                    a_d     = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                buf_d    = columns_in;
                dtheta_d = theta_q;
                col_d    = a_q;
                plane_d  = PW'(P - 1);
                cnt_d    = '0;
                state_d  = StShift;
            end
            StShift: begin
                if (cnt_q == CntW'(ShiftLen - 1)) begin
                    cnt_d   = '0;
                    state_d = StLatch;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLatch: begin
                addr_d  = a_q;
                cnt_d   = '0;
                state_d = StDisplay;
            end
            StDisplay: begin
                if (cnt_q == disp_last) begin
                    cnt_d = '0;
                    if (plane_q != '0) begin
                        plane_d = plane_q - PW'(1);
                        state_d = StShift;
                    end else begin
                        state_d = StFetch;
                        if (a_q == AW'(SCAN_RATE - 1)) begin
                            a_d = '0;
`ifndef FRAME_SYNC_EN
                            // A strobe in the wrap cycle itself beats the stored one.
                            if (theta_valid_in) begin
                                theta_d    = theta_in;
                                pend_vld_d = 1'b0;
                            end else if (pend_vld_q) begin
                                theta_d    = pend_theta_q;
                                pend_vld_d = 1'b0;
                            end
`endif
                        end else begin
                            a_d = a_q + AW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef FRAME_SYNC_EN
        // New theta restarts the frame immediately; nothing is latched or shown.
        if (state_q != StIdle && theta_valid_in) begin
            state_d = StFetch;
            a_d     = '0;
            theta_d = theta_in;
            cnt_d   = '0;
            addr_d  = addr_q;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            plane_q  <= '0;
            a_q      <= '0;
            theta_q  <= '0;
            buf_q    <= '0;
            dtheta_q <= '0;
            col_q    <= '0;
            addr_q   <= '0;
`ifndef FRAME_SYNC_EN
            pend_theta_q <= '0;
            pend_vld_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            plane_q  <= plane_d;
            a_q      <= a_d;
            theta_q  <= theta_d;
            buf_q    <= buf_d;
            dtheta_q <= dtheta_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
`ifndef FRAME_SYNC_EN
            pend_theta_q <= pend_theta_d;
            pend_vld_q   <= pend_vld_d;
`endif
        end
    end

    // Panel and frame-source outputs decoded from the current state.
    always_comb begin
        rgb1_out = 3'b000;
        rgb2_out = 3'b000;
        if (state_q == StShift) begin
            // Channel c occupies pixel bits [c*P +: P]; c=2 is R, c=0 is B.
            for (int c = 0; c < 3; c++) begin
                rgb1_out[c] = |(pix1[c*P +: P] & plane_oh);
                rgb2_out[c] = |(pix2[c*P +: P] & plane_oh);
            end
        end
        sclk_out          = (state_q == StShift) && cnt_q[0];
        latch_out         = (state_q == StLatch);
        oe_n_out          = (state_q != StDisplay);
        addr_out          = addr_q;
        // The frame source is combinational, so the request is live during FETCH.
        dtheta_out        = (state_q == StFetch) ? theta_q : dtheta_q;
        column_index1_out = (state_q == StFetch) ? a_q : col_q;
        column_index2_out = (state_q == StFetch) ? a_q : col_q;
    end

endmodule

// File: tb/tb_led_column_scanner.sv
// Directed bench for led_column_scanner with default parameters.
// Honours FRAME_SYNC_EN when the design is built with it.
module tb_led_column_scanner;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [7:0]             theta;
    logic                   theta_valid;
    logic [7:0]             dtheta;
    logic [4:0]             col1, col2;
    logic [1:0][63:0][8:0]  cols;
    logic [2:0]             rgb1, rgb2;
    logic                   sclk, latch, oe_n;
    logic [4:0]             addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int latch_cnt = 0;
    int last_fetch = -1;

    // Plane bits {R[p],G[p],B[p]} for pixel 0 of each half, indexed by plane.
    // Upper pixel 101_010_111, lower pixel 011_100_001.
    logic [2:0] exp_rgb1 [3];
    logic [2:0] exp_rgb2 [3];

    led_column_scanner dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .theta_in          (theta),
        .theta_valid_in    (theta_valid),
        .dtheta_out        (dtheta),
        .column_index1_out (col1),
        .column_index2_out (col2),
        .columns_in        (cols),
        .rgb1_out          (rgb1),
        .rgb2_out          (rgb2),
        .sclk_out          (sclk),
        .latch_out         (latch),
        .oe_n_out          (oe_n),
        .addr_out          (addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (latch) latch_cnt++;
    endtask

    // Runs one full scan address; entered and left on a FETCH cycle.
    task automatic scan(input int exp_a, input int exp_theta, input bit detail,
                        input bit strobe, input int strobe_theta);
        int n;
        if (last_fetch >= 0) check("addr_period", cyc - last_fetch, 416);
        last_fetch = cyc;
        latch_cnt  = 0;
        check("fetch_dtheta", dtheta, exp_theta);
        check("fetch_col1", col1, exp_a);
        check("fetch_col2", col2, exp_a);
        check("fetch_oe_n", oe_n, 1);
        check("fetch_latch", latch, 0);
        if (strobe) begin
            theta       = 8'(strobe_theta);
            theta_valid = 1'b1;
        end
        step();
        theta_valid = 1'b0;
        for (int p = 2; p >= 0; p--) begin
            for (int j = 0; j < 128; j++) begin
                if (detail || j == 0 || j == 127) check("shift_sclk", sclk, j % 2);
                if (j == 0) begin
                    check("shift_oe_n", oe_n, 1);
                    check("shift_dtheta_hold", dtheta, exp_theta);
                    check("shift_col_hold", col1, exp_a);
                end
                if (detail) begin
                    if (j == 0 || j == 1) begin
                        check("pix0_rgb1", rgb1, exp_rgb1[p]);
                        check("pix0_rgb2", rgb2, exp_rgb2[p]);
                    end
                    if (j == 2) begin
                        check("pix1_rgb1", rgb1, 3'b000);
                        check("pix1_rgb2", rgb2, 3'b111);
                    end
                    if (j == 126) begin
                        check("pix63_rgb1", rgb1, 3'b111);
                        check("pix63_rgb2", rgb2, 3'b000);
                    end
                end
                step();
            end
            check("latch_pulse", latch, 1);
            check("latch_sclk", sclk, 0);
            check("latch_oe_n", oe_n, 1);
            step();
            check("disp_addr", addr, exp_a);
            n = 0;
            while (oe_n == 1'b0 && n < 64) begin
                n++;
                step();
            end
            check("disp_len", n, 4 << p);
        end
        check("latch_count", latch_cnt, 3);
    endtask

    initial begin
        int bad;
        int n;
        exp_rgb1[2] = 3'b101; exp_rgb1[1] = 3'b011; exp_rgb1[0] = 3'b101;
        exp_rgb2[2] = 3'b010; exp_rgb2[1] = 3'b100; exp_rgb2[0] = 3'b101;
        cols          = '0;
        cols[0][0]    = 9'b101_010_111;
        cols[1][0]    = 9'b011_100_001;
        cols[1][1]    = 9'h1FF;
        cols[0][63]   = 9'h1FF;
        theta         = 8'h00;
        theta_valid   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        check("rst_oe_n", oe_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_latch", latch, 0);
        check("rst_rgb1", rgb1, 0);
        check("rst_rgb2", rgb2, 0);
        check("rst_addr", addr, 0);
        check("rst_dtheta", dtheta, 0);
        check("rst_col1", col1, 0);

        // No strobe: panel must stay dark and quiet.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (oe_n !== 1'b1 || sclk !== 1'b0 || latch !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        theta       = 8'h05;
        theta_valid = 1'b1;
        step();
        theta_valid = 1'b0;

        scan(0, 5, 1'b1, 1'b0, 0);
        for (int a = 1; a < 10; a++) scan(a, 5, 1'b0, 1'b0, 0);
`ifdef FRAME_SYNC_EN
        theta       = 8'd9;
        theta_valid = 1'b1;
        step();
        theta_valid = 1'b0;
        last_fetch  = -1;
        check("sync_oe_n", oe_n, 1);
        check("sync_latch", latch, 0);
        scan(0, 9, 1'b0, 1'b0, 0);
        scan(1, 9, 1'b0, 1'b0, 0);
`else
        // Strobe at a=10 must not take effect until the wrap back to 0.
        scan(10, 5, 1'b0, 1'b1, 9);
        for (int a = 11; a < 32; a++) scan(a, 5, 1'b0, 1'b0, 0);
        scan(0, 9, 1'b0, 1'b0, 0);
        scan(1, 9, 1'b0, 1'b0, 0);
`endif

        // Reset in the middle of DISPLAY for address 2.
        n = 0;
        while (oe_n == 1'b1 && n < 300) begin
            n++;
            step();
        end
        check("reach_display", oe_n, 0);
        check("pre_rst_addr", addr, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_oe_n", oe_n, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_latch", latch, 0);
        check("mid_rst_rgb1", rgb1, 0);
        check("mid_rst_rgb2", rgb2, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_dtheta", dtheta, 0);
        check("mid_rst_col2", col2, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (oe_n !== 1'b1 || sclk !== 1'b0 || latch !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
